// File: rtl/ghr_spec_ctrl.sv
// Speculative global-history controller for a gshare predictor: shifts predictions
// into the GHR at fetch, checkpoints history in an in-order FIFO, repairs on mispredict.
module ghr_spec_ctrl #(
  parameter int unsigned GHR_W  = 10,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PC_LSB = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_fetch_br,
  input  logic             i_fetch_pred,
  input  logic [31:0]      i_fetch_pc,
  input  logic             i_fetch_stall,
  input  logic             i_res_valid,
  input  logic             i_res_taken,
  input  logic             i_res_mispred,
  output logic [GHR_W-1:0] o_ghr,
  output logic [GHR_W-1:0] o_pht_rd_idx,
  output logic             o_pht_wr_en,
  output logic [GHR_W-1:0] o_pht_wr_idx,
  output logic             o_pht_wr_taken,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_stall_req,
  output logic             o_underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [GHR_W-1:0] ghr;
    logic [GHR_W-1:0] idx;
  } ckpt_t;

  ckpt_t            r_ckpt [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [GHR_W-1:0] r_ghr;
  logic             r_full;
  logic             r_empty;
  logic             r_underflow;

  logic [GHR_W-1:0] w_fetch_idx;
  ckpt_t            w_head;
  logic             w_pop;
  logic             w_mispred;
  logic             w_push;
  logic [GHR_W-1:0] w_ghr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_unused_pc;

  assign w_fetch_idx = i_fetch_pc[PC_LSB +: GHR_W];
  assign w_unused_pc = ^i_fetch_pc;
  assign w_head      = r_ckpt[r_rd_ptr];

  assign w_pop     = i_res_valid & ~r_empty;
  assign w_mispred = w_pop & i_res_mispred;
  // Recovery wins over a same-cycle push: the fetched branch is on the wrong path.
  assign w_push    = i_fetch_br & ~i_fetch_stall & ~r_full & ~w_mispred;

  always_comb begin
    w_ghr_nxt    = r_ghr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_ptr_nxt = r_wr_ptr;
    w_count_nxt  = r_count;
    if (w_mispred) begin
      w_ghr_nxt    = {w_head.ghr[GHR_W-2:0], i_res_taken};
      w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      w_wr_ptr_nxt = r_rd_ptr + PTR_W'(1);
      w_count_nxt  = '0;
    end else begin
      if (w_push) begin
        w_ghr_nxt    = {r_ghr[GHR_W-2:0], i_fetch_pred};
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      end
      w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ghr       <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_underflow <= 1'b0;
    end else begin
      r_ghr       <= w_ghr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty     <= (w_count_nxt == '0);
      r_underflow <= i_res_valid & r_empty;
    end
  end

  // Checkpoint storage needs no reset; entries are only read after being written.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_ckpt[r_wr_ptr] <= '{ghr: r_ghr, idx: w_fetch_idx};
    end
  end

  assign o_ghr          = r_ghr;
  assign o_pht_rd_idx   = w_fetch_idx ^ r_ghr;
  assign o_pht_wr_en    = w_pop;
  assign o_pht_wr_idx   = w_head.idx ^ w_head.ghr;
  assign o_pht_wr_taken = i_res_taken;
  assign o_full         = r_full;
  assign o_empty        = r_empty;
  assign o_stall_req    = i_fetch_br & r_full;
  assign o_underflow    = r_underflow;

endmodule
